lcd_timing_gen: RTL and testbench

- Generates the LCD dot/line timebase that paces the background renderer.
- Outputs:
  - the current line (LY) and dot counters;
  - the STAT mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 transfer);
  - a one-clock `drawline` pulse per visible line;
  - VBlank and STAT interrupt request pulses for the interrupt controller.
- Sits between the CPU-visible LCDC/STAT/LYC registers and the line renderer.

---
 rtl/lcd_timing_gen.sv | 161 ++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_timing_gen.sv
// LCD dot/line timebase for the background renderer.
// Holds the line (ly) and dot counters, decodes the STAT mode, and issues
// single-clock event pulses: drawline on mode-3 entry of a visible line,
// frame_start at line 0 dot 0, vblank_irq on entry to the first VBlank line,
// and stat_irq on a rising edge of the combined STAT condition.
//
// Ports:
//   clk          system clock, rising-edge
//   reset        asynchronous reset, active low
//   lcd_enable   LCDC bit 7; low holds the timebase idle at line 0 dot 0
//   lyc          LY compare value
//   stat_ie      STAT enables: [0] HBlank, [1] VBlank, [2] OAM, [3] LYC
//   ly, dot      current line / dot within line
//   mode         STAT mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 transfer)
//   lyc_match    ly == lyc while enabled
//   drawline, frame_start, vblank_irq, stat_irq   one-clock pulses
//
// state    | meaning
// ST_IDLE  | timebase held at zero; the first enabled edge starts line 0
// ST_RUN   | prescaler and dot/line counters advancing
module lcd_timing_gen #(
   parameter int CLKS_PER_DOT  = 1,
   parameter int DOTS_PER_LINE = 456,
   parameter int OAM_DOTS      = 80,
   parameter int XFER_DOTS     = 172,
   parameter int VISIBLE_LINES = 144,
   parameter int TOTAL_LINES   = 154
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       lcd_enable,
   input  logic [7:0] lyc,
   input  logic [3:0] stat_ie,
   output logic [7:0] ly,
   output logic [8:0] dot,
   output logic [1:0] mode,
   output logic       lyc_match,
   output logic       drawline,
   output logic       frame_start,
   output logic       vblank_irq,
   output logic       stat_irq
);

   localparam int PW = (CLKS_PER_DOT > 1) ? $clog2(CLKS_PER_DOT) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_DOT - 1);
   localparam logic [8:0]    DOT_LAST   = 9'(DOTS_PER_LINE - 1);
   localparam logic [8:0]    DOT_OAM    = 9'(OAM_DOTS);
   localparam logic [8:0]    DOT_OAM_M1 = 9'(OAM_DOTS - 1);
   localparam logic [8:0]    DOT_XFER   = 9'(OAM_DOTS + XFER_DOTS);
   localparam logic [7:0]    LY_LAST    = 8'(TOTAL_LINES - 1);
   localparam logic [7:0]    LY_VIS     = 8'(VISIBLE_LINES);
   localparam logic [7:0]    LY_VIS_M1  = 8'(VISIBLE_LINES - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [8:0]      dot_q, dot_d;
   logic [7:0]      ly_q, ly_d;
   logic            drawline_q, drawline_d;
   logic            frame_start_q, frame_start_d;
   logic            vblank_irq_q, vblank_irq_d;
   logic            stat_prev_q, stat_prev_d;
   logic            stat_irq_q, stat_irq_d;
   logic            tick;
   logic            stat_line;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         presc_q       <= '0;
         dot_q         <= '0;
         ly_q          <= '0;
         drawline_q    <= 1'b0;
         frame_start_q <= 1'b0;
         vblank_irq_q  <= 1'b0;
         stat_prev_q   <= 1'b0;
         stat_irq_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         presc_q       <= presc_d;
         dot_q         <= dot_d;
         ly_q          <= ly_d;
         drawline_q    <= drawline_d;
         frame_start_q <= frame_start_d;
         vblank_irq_q  <= vblank_irq_d;
         stat_prev_q   <= stat_prev_d;
         stat_irq_q    <= stat_irq_d;
      end
   end

   // next state and counters
   always_comb begin
      state_d       = lcd_enable ? ST_RUN : ST_IDLE;
      presc_d       = presc_q;
      dot_d         = dot_q;
      ly_d          = ly_q;
      drawline_d    = 1'b0;
      frame_start_d = 1'b0;
      vblank_irq_d  = 1'b0;
      tick          = 1'b0;
      if (!lcd_enable) begin
         presc_d = '0;
         dot_d   = '0;
         ly_d    = '0;
      end else if (state_q == ST_IDLE) begin
         presc_d       = '0;
         dot_d         = '0;
         ly_d          = '0;
         frame_start_d = 1'b1;
      end else begin
         tick    = (presc_q == PRESC_LAST);
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick) begin
            if (dot_q == DOT_LAST) begin
               dot_d = '0;
               if (ly_q == LY_LAST) begin
                  ly_d          = '0;
                  frame_start_d = 1'b1;
               end else begin
                  ly_d         = ly_q + 8'd1;
                  vblank_irq_d = (ly_q == LY_VIS_M1);
               end
            end else begin
               dot_d      = dot_q + 9'd1;
               drawline_d = (dot_q == DOT_OAM_M1) && (ly_q < LY_VIS);
            end
         end
      end
   end

   // outputs: mode decode, LYC compare, STAT edge detect
   always_comb begin
      mode = 2'd0;
      if (state_q == ST_RUN) begin
         if (ly_q >= LY_VIS)         mode = 2'd1;
         else if (dot_q < DOT_OAM)   mode = 2'd2;
         else if (dot_q < DOT_XFER)  mode = 2'd3;
         else                        mode = 2'd0;
      end
      lyc_match = lcd_enable && (state_q == ST_RUN) && (ly_q == lyc);
      // Gated by running as well so the start-up cycle (mode reads 0) cannot
      // look like an HBlank entry.
      stat_line = lcd_enable && (state_q == ST_RUN) &&
                  ((stat_ie[0] && mode == 2'd0) ||
                   (stat_ie[1] && mode == 2'd1) ||
                   (stat_ie[2] && mode == 2'd2) ||
                   (stat_ie[3] && lyc_match));
      stat_prev_d = stat_line;
      stat_irq_d  = stat_line && !stat_prev_q;
   end

   assign ly          = ly_q;
   assign dot         = dot_q;
   assign drawline    = drawline_q;
   assign frame_start = frame_start_q;
   assign vblank_irq  = vblank_irq_q;
   assign stat_irq    = stat_irq_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
module tb_lcd_timing_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       en_ab;
   logic       en_c;
   logic [7:0] lyc;
   logic [3:0] stat_ie;

   logic [7:0] a_ly, b_ly, c_ly;
   logic [8:0] a_dot, b_dot, c_dot;
   logic [1:0] a_mode, b_mode, c_mode;
   logic       a_lyc_match, b_lyc_match, c_lyc_match;
   logic       a_drawline, b_drawline, c_drawline;
   logic       a_frame_start, b_frame_start, c_frame_start;
   logic       a_vblank_irq, b_vblank_irq, c_vblank_irq;
   logic       a_stat_irq, b_stat_irq, c_stat_irq;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int n_fs = 0, n_draw = 0, n_vb = 0, n_stat = 0, n_any = 0;

   always #5 clk = ~clk;

   lcd_timing_gen u_a (
      .clk(clk), .reset(reset), .lcd_enable(en_ab), .lyc(lyc), .stat_ie(stat_ie),
      .ly(a_ly), .dot(a_dot), .mode(a_mode), .lyc_match(a_lyc_match),
      .drawline(a_drawline), .frame_start(a_frame_start),
      .vblank_irq(a_vblank_irq), .stat_irq(a_stat_irq)
   );

   lcd_timing_gen #(.CLKS_PER_DOT(4)) u_b (
      .clk(clk), .reset(reset), .lcd_enable(en_ab), .lyc(lyc), .stat_ie(stat_ie),
      .ly(b_ly), .dot(b_dot), .mode(b_mode), .lyc_match(b_lyc_match),
      .drawline(b_drawline), .frame_start(b_frame_start),
      .vblank_irq(b_vblank_irq), .stat_irq(b_stat_irq)
   );

   lcd_timing_gen u_c (
      .clk(clk), .reset(reset), .lcd_enable(en_c), .lyc(lyc), .stat_ie(stat_ie),
      .ly(c_ly), .dot(c_dot), .mode(c_mode), .lyc_match(c_lyc_match),
      .drawline(c_drawline), .frame_start(c_frame_start),
      .vblank_irq(c_vblank_irq), .stat_irq(c_stat_irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      n_fs   += int'(a_frame_start);
      n_draw += int'(a_drawline);
      n_vb   += int'(a_vblank_irq);
      n_stat += int'(a_stat_irq);
      n_any  += int'(a_frame_start | a_drawline | a_vblank_irq | a_stat_irq |
                     b_frame_start | b_drawline | b_vblank_irq | b_stat_irq |
                     c_frame_start | c_drawline | c_vblank_irq | c_stat_irq);
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   initial begin
      reset   = 1'b0;
      en_ab   = 1'b0;
      en_c    = 1'b0;
      lyc     = 8'd5;
      stat_ie = 4'b1000;
      #2;
      chk("rst_ly", 32'(a_ly), 0);
      chk("rst_dot", 32'(a_dot), 0);
      chk("rst_mode", 32'(a_mode), 0);
      chk("rst_lyc_match", 32'(a_lyc_match), 0);
      chk("rst_pulses", {28'd0, a_drawline, a_frame_start, a_vblank_irq, a_stat_irq}, 0);

      @(negedge clk);
      reset = 1'b1;
      repeat (100) step();
      chk("hold_ly", 32'(a_ly), 0);
      chk("hold_dot", 32'(a_dot), 0);
      chk("hold_mode", 32'(a_mode), 0);
      chk("hold_c_ly", 32'(c_ly), 0);
      chk("hold_pulses", 32'(n_any), 0);

      // Enable; the next rising edge is E (cyc 0)
      en_ab = 1'b1;
      en_c  = 1'b1;
      cyc = -1; n_fs = 0; n_draw = 0; n_vb = 0; n_stat = 0;
      step();
      chk("e_frame_start", 32'(a_frame_start), 1);
      chk("e_ly", 32'(a_ly), 0);
      chk("e_dot", 32'(a_dot), 0);
      chk("e_mode", 32'(a_mode), 2);
      chk("e_b_frame_start", 32'(b_frame_start), 1);
      chk("e_b_mode", 32'(b_mode), 2);
      run_to(1);
      chk("e1_frame_start", 32'(a_frame_start), 0);
      chk("e1_dot", 32'(a_dot), 1);
      run_to(3);
      chk("b_dot_c3", 32'(b_dot), 0);
      run_to(4);
      chk("b_dot_c4", 32'(b_dot), 1);
      chk("b_mode_c4", 32'(b_mode), 2);
      run_to(79);
      chk("mode_d79", 32'(a_mode), 2);
      chk("dot_d79", 32'(a_dot), 79);
      chk("draw_d79", 32'(a_drawline), 0);
      run_to(80);
      chk("draw_d80", 32'(a_drawline), 1);
      chk("mode_d80", 32'(a_mode), 3);
      run_to(81);
      chk("draw_d81", 32'(a_drawline), 0);
      chk("mode_d81", 32'(a_mode), 3);
      run_to(251);
      chk("mode_d251", 32'(a_mode), 3);
      run_to(252);
      chk("mode_d252", 32'(a_mode), 0);
      chk("dot_d252", 32'(a_dot), 252);
      run_to(319);
      chk("b_draw_319", 32'(b_drawline), 0);
      chk("b_dot_319", 32'(b_dot), 79);
      run_to(320);
      chk("b_draw_320", 32'(b_drawline), 1);
      chk("b_dot_320", 32'(b_dot), 80);
      chk("b_mode_320", 32'(b_mode), 3);
      run_to(321);
      chk("b_draw_321", 32'(b_drawline), 0);
      run_to(455);
      chk("ly_c455", 32'(a_ly), 0);
      chk("dot_c455", 32'(a_dot), 455);
      chk("mode_c455", 32'(a_mode), 0);
      run_to(456);
      chk("ly_c456", 32'(a_ly), 1);
      chk("dot_c456", 32'(a_dot), 0);
      chk("mode_c456", 32'(a_mode), 2);
      chk("ndraw_c456", 32'(n_draw), 1);

      // LYC match on line 5 with only the LYC source enabled
      run_to(2279);
      chk("ly_c2279", 32'(a_ly), 4);
      chk("lycm_c2279", 32'(a_lyc_match), 0);
      run_to(2280);
      chk("ly_c2280", 32'(a_ly), 5);
      chk("lycm_c2280", 32'(a_lyc_match), 1);
      chk("stat_c2280", 32'(a_stat_irq), 0);
      run_to(2281);
      chk("stat_c2281", 32'(a_stat_irq), 1);
      run_to(2282);
      chk("stat_c2282", 32'(a_stat_irq), 0);
      run_to(2735);
      chk("lycm_c2735", 32'(a_lyc_match), 1);
      run_to(2736);
      chk("lycm_c2736", 32'(a_lyc_match), 0);
      chk("ly_c2736", 32'(a_ly), 6);
      chk("nstat_lyc", 32'(n_stat), 1);

      // HBlank + OAM sources: one pulse per line at HBlank entry
      stat_ie = 4'b0101;
      n_stat = 0;
      run_to(2988);
      chk("stat_c2988", 32'(a_stat_irq), 0);
      chk("mode_c2988", 32'(a_mode), 0);
      run_to(2989);
      chk("stat_c2989", 32'(a_stat_irq), 1);
      run_to(2990);
      chk("stat_c2990", 32'(a_stat_irq), 0);
      run_to(3192);
      chk("ly_c3192", 32'(a_ly), 7);
      chk("mode_c3192", 32'(a_mode), 2);
      chk("stat_c3192", 32'(a_stat_irq), 0);
      run_to(3193);
      chk("stat_c3193", 32'(a_stat_irq), 0);
      run_to(4560);
      chk("nstat_hb_oam", 32'(n_stat), 4);

      stat_ie = 4'b0010;
      n_stat = 0;

      // Mid-frame disable on the third instance
      run_to(32120);
      chk("c_ly_70", 32'(c_ly), 70);
      chk("c_dot_200", 32'(c_dot), 200);
      chk("c_mode_200", 32'(c_mode), 3);
      en_c = 1'b0;
      run_to(32121);
      chk("c_dis_ly", 32'(c_ly), 0);
      chk("c_dis_dot", 32'(c_dot), 0);
      chk("c_dis_mode", 32'(c_mode), 0);
      chk("c_dis_fs", 32'(c_frame_start), 0);
      run_to(32125);
      chk("c_hold_dot", 32'(c_dot), 0);
      en_c = 1'b1;
      run_to(32126);
      chk("c_re_fs", 32'(c_frame_start), 1);
      chk("c_re_ly", 32'(c_ly), 0);
      chk("c_re_dot", 32'(c_dot), 0);
      chk("c_re_mode", 32'(c_mode), 2);
      run_to(32127);
      chk("c_re_fs1", 32'(c_frame_start), 0);
      chk("c_re_dot1", 32'(c_dot), 1);

      // VBlank entry: vblank_irq then stat_irq (mode-1 source) next clock
      run_to(65663);
      chk("ly_c65663", 32'(a_ly), 143);
      chk("vb_c65663", 32'(a_vblank_irq), 0);
      run_to(65664);
      chk("vb_c65664", 32'(a_vblank_irq), 1);
      chk("ly_c65664", 32'(a_ly), 144);
      chk("mode_c65664", 32'(a_mode), 1);
      chk("stat_c65664", 32'(a_stat_irq), 0);
      run_to(65665);
      chk("vb_c65665", 32'(a_vblank_irq), 0);
      chk("stat_c65665", 32'(a_stat_irq), 1);
      lyc = 8'd144;
      #1;
      chk("lycm_live", 32'(a_lyc_match), 1);
      lyc = 8'd5;
      #1;
      chk("lycm_live_off", 32'(a_lyc_match), 0);
      run_to(65666);
      chk("stat_c65666", 32'(a_stat_irq), 0);
      run_to(69768);
      chk("ly_c69768", 32'(a_ly), 153);
      chk("dot_c69768", 32'(a_dot), 0);
      chk("mode_c69768", 32'(a_mode), 1);
      run_to(70223);
      chk("dot_c70223", 32'(a_dot), 455);
      chk("ndraw_frame", 32'(n_draw), 144);
      chk("nvb_frame", 32'(n_vb), 1);
      chk("nfs_frame", 32'(n_fs), 1);
      chk("nstat_vb", 32'(n_stat), 1);
      run_to(70224);
      chk("fs_c70224", 32'(a_frame_start), 1);
      chk("ly_c70224", 32'(a_ly), 0);
      chk("dot_c70224", 32'(a_dot), 0);
      chk("mode_c70224", 32'(a_mode), 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
